alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_if.sv | 52 +++++
 rtl/alu_exec.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_exec.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_if
//  Purpose  : Bundles the instruction, status and memory signals exchanged
//             between the upstream pipeline register and the alu_exec stage.
//  Modports : master - upstream stage (drives instruction fields, sees stall
//                      and the registered results)
//             slave  - alu_exec (consumes instruction fields, drives results)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_if;
    // Instruction fields from the upstream pipeline register
    logic       in_valid;
    logic [3:0] opcode;
    logic [7:0] value;
    logic [7:0] labelValue;
    logic       labelFlag;
    logic       writeMemFlag;
    logic       readMemFlag;
    logic [7:0] regA;
    logic [7:0] regB;
    logic       immediateFlag;
    logic       signFlag;

    // Results and control back to the pipeline
    logic       stall;
    logic       out_valid;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_read;
    logic       mem_write;

    modport master (
        output in_valid, opcode, value, labelValue, labelFlag,
               writeMemFlag, readMemFlag, regA, regB, immediateFlag, signFlag,
        input  stall, out_valid, result, zero, carry, branch_taken,
               branch_target, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  in_valid, opcode, value, labelValue, labelFlag,
               writeMemFlag, readMemFlag, regA, regB, immediateFlag, signFlag,
        output stall, out_valid, result, zero, carry, branch_taken,
               branch_target, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Purpose  : Execute stage. Single-cycle ALU, load/store address generation
//             and branch resolution, plus an 8-cycle shift-add multiplier
//             that stalls the upstream stage while it runs.
//  Ports    : clk   - clock, all state changes on the rising edge
//             rst_n - asynchronous active-low reset
//             bus   - alu_exec_if.slave: instruction fields in; stall,
//                     out_valid, result, flags, branch and memory outputs out
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_exec_if.slave   bus
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_MUL = 4'h7;
    localparam logic [3:0] OP_SLT = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_BNE = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] mul_a_q;
    logic [7:0] mul_b_q;
    logic [7:0] mul_acc_q;
    logic [2:0] mul_cnt_q;

    logic       out_valid_q;
    logic [7:0] result_q;
    logic       zero_q;
    logic       carry_q;
    logic       branch_taken_q;
    logic [7:0] branch_target_q;
    logic [7:0] mem_addr_q;
    logic [7:0] mem_wdata_q;
    logic       mem_read_q;
    logic       mem_write_q;

    logic [7:0] opb_d;
    logic [2:0] shamt_d;
    logic [8:0] add_d;
    logic [8:0] shl_d;
    logic [8:0] shr_d;
    logic [7:0] alu_res_d;
    logic       alu_carry_d;
    logic [7:0] mul_sum_d;

    assign opb_d   = bus.immediateFlag ? bus.value : bus.regB;
    assign shamt_d = opb_d[2:0];
    assign add_d   = {1'b0, bus.regA} + {1'b0, opb_d};

    // Shifts are done on a 9-bit window so the last bit shifted out lands
    // in the extra bit: bit 8 for SHL, bit 0 for SHR. A zero shift leaves
    // that bit 0, which is the required carry for amount 0.
    assign shl_d = {1'b0, bus.regA} << shamt_d;
    assign shr_d = bus.signFlag ? $unsigned($signed({bus.regA, 1'b0}) >>> shamt_d)
                                : ({bus.regA, 1'b0} >> shamt_d);

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. Only the low 8 bits of the product are kept.
    assign mul_sum_d = mul_acc_q + (mul_a_q[0] ? mul_b_q : 8'h00);

    always_comb begin
        alu_res_d   = 8'h00;
        alu_carry_d = 1'b0;
        unique case (bus.opcode)
            OP_ADD: begin
                alu_res_d   = add_d[7:0];
                alu_carry_d = add_d[8];
            end
            OP_SUB: begin
                alu_res_d   = bus.regA - opb_d;
                alu_carry_d = (bus.regA < opb_d);
            end
            OP_AND: alu_res_d = bus.regA & opb_d;
            OP_OR:  alu_res_d = bus.regA | opb_d;
            OP_XOR: alu_res_d = bus.regA ^ opb_d;
            OP_SHL: begin
                alu_res_d   = shl_d[7:0];
                alu_carry_d = shl_d[8];
            end
            OP_SHR: begin
                alu_res_d   = shr_d[8:1];
                alu_carry_d = shr_d[0];
            end
            OP_SLT: begin
                if (bus.signFlag) begin
                    alu_res_d = {7'b0, ($signed(bus.regA) < $signed(opb_d))};
                end else begin
                    alu_res_d = {7'b0, (bus.regA < opb_d)};
                end
            end
            OP_MOV: alu_res_d = opb_d;
            default: begin
                alu_res_d   = 8'h00;
                alu_carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            mul_a_q         <= 8'h00;
            mul_b_q         <= 8'h00;
            mul_acc_q       <= 8'h00;
            mul_cnt_q       <= 3'd0;
            out_valid_q     <= 1'b0;
            result_q        <= 8'h00;
            zero_q          <= 1'b0;
            carry_q         <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= 8'h00;
            mem_addr_q      <= 8'h00;
            mem_wdata_q     <= 8'h00;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
        end else begin
            // Pulse outputs default low; everything else holds.
            out_valid_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        unique case (bus.opcode)
                            OP_MUL: begin
                                state_q   <= ST_MUL;
                                mul_a_q   <= bus.regA;
                                mul_b_q   <= opb_d;
                                mul_acc_q <= 8'h00;
                                mul_cnt_q <= 3'd0;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                            OP_SHL, OP_SHR, OP_SLT, OP_MOV: begin
                                out_valid_q <= 1'b1;
                                result_q    <= alu_res_d;
                                carry_q     <= alu_carry_d;
                                zero_q      <= (alu_res_d == 8'h00);
                            end
                            OP_LD, OP_ST: begin
                                out_valid_q <= 1'b1;
                                mem_addr_q  <= opb_d;
                                mem_read_q  <= bus.readMemFlag;
                                mem_write_q <= bus.writeMemFlag;
                                if (bus.opcode == OP_ST) begin
                                    mem_wdata_q <= bus.regA;
                                end
                            end
                            OP_BEQ, OP_BNE, OP_JMP: begin
                                out_valid_q     <= 1'b1;
                                branch_target_q <= bus.labelFlag ? bus.labelValue : bus.value;
                                if (bus.opcode == OP_BEQ) begin
                                    branch_taken_q <= (bus.regA == bus.regB);
                                end else if (bus.opcode == OP_BNE) begin
                                    branch_taken_q <= (bus.regA != bus.regB);
                                end else begin
                                    branch_taken_q <= 1'b1;
                                end
                            end
                            default: begin
                                // NOP: completes with a zero result, flags untouched.
                                out_valid_q <= 1'b1;
                                result_q    <= 8'h00;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    mul_acc_q <= mul_sum_d;
                    mul_a_q   <= mul_a_q >> 1;
                    mul_b_q   <= mul_b_q << 1;
                    mul_cnt_q <= mul_cnt_q + 3'd1;
                    if (mul_cnt_q == 3'd7) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_sum_d;
                        zero_q      <= (mul_sum_d == 8'h00);
                        carry_q     <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall comes straight from the state so reset drops it immediately and
    // it stays low during the cycle in which a multiply is accepted.
    assign bus.stall         = (state_q == ST_MUL);
    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.zero          = zero_q;
    assign bus.carry         = carry_q;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.branch_target = branch_target_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Directed self-checking bench for alu_exec. Stimulus pushes
//             hand-computed expected responses into a queue; a monitor pops
//             and compares whenever out_valid is high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

    typedef struct packed {
        logic [7:0] result;
        logic       zero;
        logic       carry;
        logic       bt;
        logic [7:0] btgt;
        logic [7:0] maddr;
        logic [7:0] wdata;
        logic       rd;
        logic       wr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    exp_t exp_q[$];

    alu_exec_if bus ();

    alu_exec u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] res, input logic z, input logic c,
                                input logic bt, input logic [7:0] btgt,
                                input logic [7:0] maddr, input logic [7:0] wd,
                                input logic rd, input logic wr);
        exp_t e;
        e.result = res; e.zero = z; e.carry = c; e.bt = bt; e.btgt = btgt;
        e.maddr = maddr; e.wdata = wd; e.rd = rd; e.wr = wr;
        return e;
    endfunction

    function automatic exp_t actual();
        return mk(bus.result, bus.zero, bus.carry, bus.branch_taken, bus.branch_target,
                  bus.mem_addr, bus.mem_wdata, bus.mem_read, bus.mem_write);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] val, input logic imm, input logic sgn,
                             input logic lf, input logic [7:0] lv,
                             input logic rdf, input logic wrf);
        bus.in_valid      = 1'b1;
        bus.opcode        = op;
        bus.regA          = a;
        bus.regB          = b;
        bus.value         = val;
        bus.immediateFlag = imm;
        bus.signFlag      = sgn;
        bus.labelFlag     = lf;
        bus.labelValue    = lv;
        bus.readMemFlag   = rdf;
        bus.writeMemFlag  = wrf;
    endtask

    // Issue one single-cycle instruction and record its expected response.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] val, input logic imm, input logic sgn,
                        input logic lf, input logic [7:0] lv,
                        input logic rdf, input logic wrf, input exp_t e);
        set_instr(op, a, b, val, imm, sgn, lf, lv, rdf, wrf);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compares every completed instruction against the scoreboard
    // and checks that the pulse outputs never appear without out_valid.
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                a = actual();
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_out_valid: actual out_valid=1 required=0 (result=%02h)",
                             bus.result);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_fails++;
                        $display("FAIL response: actual res=%02h z=%b c=%b bt=%b tgt=%02h addr=%02h wd=%02h rd=%b wr=%b required res=%02h z=%b c=%b bt=%b tgt=%02h addr=%02h wd=%02h rd=%b wr=%b",
                                 a.result, a.zero, a.carry, a.bt, a.btgt, a.maddr, a.wdata, a.rd, a.wr,
                                 e.result, e.zero, e.carry, e.bt, e.btgt, e.maddr, e.wdata, e.rd, e.wr);
                    end
                end
            end else begin
                check("pulses_without_valid",
                      {29'b0, bus.branch_taken, bus.mem_read, bus.mem_write}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stimulus
        int stall_cnt;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        set_instr(4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b0;

        #3;
        check("reset_outputs", {actual(), bus.out_valid, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //     op    regA   regB   value  imm   sgn   lf    label  rd    wr        res  z  c  bt tgt    addr   wd     rd wr
        send(4'h0, 8'hF0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h10,1,1,0,8'h00,8'h00,8'h00,0,0) ^ mk(8'h00,1,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'h0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h00,1,1,0,8'h00,8'h00,8'h00,0,0));
        send(4'h1, 8'h05, 8'h99, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h00,1,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'h1, 8'h03, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'hFE,0,1,0,8'h00,8'h00,8'h00,0,0));
        send(4'h6, 8'h84, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'hC2,0,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'h6, 8'h84, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h42,0,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'h5, 8'h81, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h02,0,1,0,8'h00,8'h00,8'h00,0,0));
        send(4'h8, 8'hFF, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h01,0,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'h8, 8'hFF, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h00,1,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'h2, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h30,0,0,0,8'h00,8'h00,8'h00,0,0));
        send(4'hC, 8'h33, 8'h33, 8'h55, 1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0, mk(8'h30,0,0,1,8'h1A,8'h00,8'h00,0,0));
        send(4'hD, 8'h33, 8'h33, 8'h55, 1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0, mk(8'h30,0,0,0,8'h1A,8'h00,8'h00,0,0));
        send(4'hE, 8'h00, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0, 8'h1A, 1'b0, 1'b0, mk(8'h30,0,0,1,8'h77,8'h00,8'h00,0,0));
        send(4'hB, 8'h5A, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mk(8'h30,0,0,0,8'h77,8'h40,8'h5A,0,1));
        send(4'hA, 8'h11, 8'h00, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, mk(8'h30,0,0,0,8'h77,8'h41,8'h5A,1,0));
        send(4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h00,0,0,0,8'h77,8'h41,8'h5A,0,0));

        // Multiply with the next instruction held on the inputs while stalled.
        set_instr(4'h7, 8'h0D, 8'h0B, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        exp_q.push_back(mk(8'h8F,0,0,0,8'h77,8'h41,8'h5A,0,0));
        @(posedge clk);
        #1;
        set_instr(4'h0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        exp_q.push_back(mk(8'h02,0,0,0,8'h77,8'h41,8'h5A,0,0));
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.stall !== 1'b1) break;
            stall_cnt++;
        end
        check("mul_stall_cycles", stall_cnt, 32'd8);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during the fourth multiply iteration.
        set_instr(4'h7, 8'h0D, 8'h0B, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_mul_stall", bus.stall, 32'd0);
        check("reset_mid_mul_valid", bus.out_valid, 32'd0);
        check("reset_mid_mul_result", bus.result, 32'd0);
        check("reset_mid_mul_all", actual(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h02,0,0,0,8'h00,8'h00,8'h00,0,0));

        repeat (12) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
